// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: bundles the RAM/IO pins and the icache/LSB request buses of the memory arbiter
interface mem_arbiter_if #(
  parameter int LINE_BYTES = 16,
  parameter int ADDR_W     = 32
);
  logic                    rdy_in;
  logic                    io_buffer_full;
  logic [7:0]              mem_din;
  logic [7:0]              mem_dout;
  logic [ADDR_W-1:0]       mem_a;
  logic                    mem_wr;
  logic                    if_req;
  logic [ADDR_W-1:0]       if_addr;
  logic                    if_done;
  logic [LINE_BYTES*8-1:0] if_line;
  logic                    ls_req;
  logic                    ls_wr;
  logic [ADDR_W-1:0]       ls_addr;
  logic [1:0]              ls_size;
  logic [31:0]             ls_wdata;
  logic                    ls_done;
  logic [31:0]             ls_rdata;
  logic                    flush;
  modport slave (
    input  rdy_in, io_buffer_full, mem_din, if_req, if_addr, ls_req, ls_wr, ls_addr, ls_size,
           ls_wdata, flush,
    output mem_dout, mem_a, mem_wr, if_done, if_line, ls_done, ls_rdata
  );
  modport master (
    output rdy_in, io_buffer_full, mem_din, if_req, if_addr, ls_req, ls_wr, ls_addr, ls_size,
           ls_wdata, flush,
    input  mem_dout, mem_a, mem_wr, if_done, if_line, ls_done, ls_rdata
  );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares the byte-wide RAM/IO port between icache refills and the load/store buffer
// Ports: clk_in/rst_in (sync active-high reset); bus.slave carries rdy_in, io_buffer_full,
// mem_din/mem_dout/mem_a/mem_wr pins, if_req/if_addr/if_done/if_line refill port,
// ls_req/ls_wr/ls_addr/ls_size/ls_wdata/ls_done/ls_rdata load/store port and flush.
module mem_arbiter #(
  parameter int LINE_BYTES = 16,
  parameter int ADDR_W     = 32
) (
  input logic          clk_in,
  input logic          rst_in,
  mem_arbiter_if.slave bus
);
  localparam int CW = $clog2(LINE_BYTES) + 1;
  localparam logic [1:0] IDLE = 2'd0, RD = 2'd1, WR = 2'd2, IO_WAIT = 2'd3;
  logic [1:0]              st;
  logic                    who, last_ls, pend;
  logic [CW-1:0]           cnt, len, pidx;
  logic [ADDR_W-1:0]       base, a_q, cur, live_a;
  logic [31:0]             wdata;
  logic [LINE_BYTES*8-1:0] line;
  logic [7:0]              live_d;
  logic                    grant_ls, grant_if, io_stall, live_wr, done_c;
  always_comb begin
    cur = base + ADDR_W'(cnt);
    grant_ls = bus.ls_req && !bus.flush && (!bus.if_req || !last_ls);
    grant_if = bus.if_req && !bus.flush && !grant_ls;
    io_stall = st == WR && cnt < len && cur[17:16] == 2'b11 && bus.io_buffer_full;
    live_wr = st == WR && cnt < len && !io_stall;
    live_a = (live_wr || (st == RD && cnt < len)) ? cur : '0;
    live_d = live_wr ? wdata[{cnt[1:0], 3'b000} +: 8] : 8'h00;
    done_c = bus.rdy_in && cnt == len && (st == WR || (st == RD && !pend && !bus.flush));
    bus.mem_wr = live_wr && bus.rdy_in;
    bus.mem_a = bus.rdy_in ? live_a : a_q;
    bus.mem_dout = live_d;
    bus.if_done = done_c && !who;
    bus.ls_done = done_c && who;
    bus.if_line = line;
    bus.ls_rdata = line[31:0];
  end
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      st <= IDLE;
      who <= 1'b0;
      last_ls <= 1'b0;
      pend <= 1'b0;
      cnt <= '0;
      len <= '0;
      pidx <= '0;
      base <= '0;
      a_q <= '0;
      wdata <= '0;
      line <= '0;
    end else if (bus.rdy_in) begin
      a_q <= live_a;
      case (st)
        IDLE: if (grant_ls || grant_if) begin
          st <= (grant_ls && bus.ls_wr) ? WR : RD;
          who <= grant_ls;
          last_ls <= grant_ls;
          base <= grant_ls ? bus.ls_addr : bus.if_addr;
          len <= !grant_ls ? CW'(LINE_BYTES) : bus.ls_size == 2'd0 ? CW'(1) :
                 bus.ls_size == 2'd1 ? CW'(2) : CW'(4);
          wdata <= bus.ls_wdata;
          cnt <= '0;
          pend <= 1'b0;
          line <= '0;
        end
        RD: if (bus.flush || done_c) begin
          st <= IDLE;
          pend <= 1'b0;
        end else begin
          // pend/pidx track the address issued last cycle whose byte is on mem_din now
          if (pend) line[{pidx, 3'b000} +: 8] <= bus.mem_din;
          pend <= cnt < len;
          pidx <= cnt;
          if (cnt < len) cnt <= cnt + CW'(1);
        end
        WR: if (done_c) st <= IDLE;
            else if (io_stall) st <= IO_WAIT;
            else cnt <= cnt + CW'(1);
        IO_WAIT: if (!bus.io_buffer_full) st <= WR;
      endcase
    end else if (st == RD && pend) begin
      // a pause drops the in-flight read byte, so rewind to re-issue it on resume
      pend <= 1'b0;
      cnt <= pidx;
    end
  end
endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;
  localparam int LB = 16, AW = 32;
  logic clk_in = 1'b0;
  logic rst_in;
  always #5 clk_in = ~clk_in;
  mem_arbiter_if #(.LINE_BYTES(LB), .ADDR_W(AW)) bus ();
  mem_arbiter #(.LINE_BYTES(LB), .ADDR_W(AW)) dut (.clk_in(clk_in), .rst_in(rst_in), .bus(bus));
  int n_checks = 0, n_errors = 0, cyc = 0, n_ifd = 0, n_lsd = 0, n_ovl = 0, lsd_cyc = 0;
  int n;
  logic [31:0] rd_a[$], wr_a[$];
  logic [7:0]  wr_d[$];
  int          wr_c[$];
  logic [LB*8-1:0] exp_line;
  function automatic logic [7:0] ram_byte(input logic [31:0] a);
    logic [3:0] k;
    k = a[3:0] + 4'd1;
    return (a >= 32'h1000 && a <= 32'h1003) ? {k, k} : a[7:0] + 8'h5A;
  endfunction
  always @(posedge clk_in) bus.mem_din <= ram_byte(bus.mem_a);
  always @(negedge clk_in) begin
    cyc++;
    if (bus.mem_wr) begin
      wr_a.push_back(bus.mem_a);
      wr_d.push_back(bus.mem_dout);
      wr_c.push_back(cyc);
    end
    if (bus.rdy_in && !bus.mem_wr && bus.mem_a != '0) rd_a.push_back(bus.mem_a);
    if (bus.if_done) n_ifd++;
    if (bus.ls_done) begin
      n_lsd++;
      lsd_cyc = cyc;
    end
    if (bus.if_done && bus.ls_done) n_ovl++;
  end
  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic next;
    @(posedge clk_in);
    #1;
  endtask
  task automatic sample;
    @(negedge clk_in);
    #1;
  endtask
  task automatic do_reset;
    rst_in = 1'b1;
    bus.rdy_in = 1'b1;
    bus.io_buffer_full = 1'b0;
    bus.if_req = 1'b0;
    bus.if_addr = '0;
    bus.ls_req = 1'b0;
    bus.ls_wr = 1'b0;
    bus.ls_addr = '0;
    bus.ls_size = 2'd0;
    bus.ls_wdata = '0;
    bus.flush = 1'b0;
    repeat (2) next();
    rst_in = 1'b0;
    rd_a.delete();
    wr_a.delete();
    wr_d.delete();
    wr_c.delete();
    n_ifd = 0;
    n_lsd = 0;
    n_ovl = 0;
  endtask
  task automatic ls_go(input logic wr, input logic [31:0] addr, input logic [1:0] size,
                       input logic [31:0] wd);
    bus.ls_req = 1'b1;
    bus.ls_wr = wr;
    bus.ls_addr = addr;
    bus.ls_size = size;
    bus.ls_wdata = wd;
  endtask
  task automatic wait_done(input string tag, input logic ls, output int cnt);
    cnt = 0;
    forever begin
      sample();
      if (ls ? bus.ls_done : bus.if_done) return;
      cnt++;
      if (cnt > 60) begin
        check({tag, "_done_seen"}, ls ? bus.ls_done : bus.if_done, 1);
        return;
      end
    end
  endtask
  task automatic check_idle_outputs(input string tag);
    check({tag, "_mem_a"}, bus.mem_a, 0);
    check({tag, "_mem_wr"}, bus.mem_wr, 0);
    check({tag, "_mem_dout"}, bus.mem_dout, 0);
    check({tag, "_if_done"}, bus.if_done, 0);
    check({tag, "_ls_done"}, bus.ls_done, 0);
    check({tag, "_ls_rdata"}, bus.ls_rdata, 0);
    check({tag, "_if_line"}, bus.if_line, 0);
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end
  initial begin
    // reset state and word load
    do_reset();
    sample();
    check_idle_outputs("rst");
    next();
    ls_go(1'b0, 32'h1000, 2'd2, 32'h0);
    wait_done("t1", 1'b1, n);
    check("t1_latency", n, 6);
    check("t1_rdata", bus.ls_rdata, 32'h44332211);
    check("t1_nreads", rd_a.size(), 4);
    check("t1_addr0", rd_a.size() > 0 ? rd_a[0] : 32'hx, 32'h1000);
    check("t1_addr3", rd_a.size() > 3 ? rd_a[3] : 32'hx, 32'h1003);
    check("t1_nwrites", wr_a.size(), 0);
    next();
    bus.ls_req = 1'b0;
    sample();
    check("t1_pulse", bus.ls_done, 0);
    // simultaneous requests: LS first, then IF on the next conflict, then LS again
    do_reset();
    bus.if_req = 1'b1;
    bus.if_addr = 32'h2000;
    ls_go(1'b0, 32'h1000, 2'd2, 32'h0);
    wait_done("t2_ls", 1'b1, n);
    check("t2_ls_first", n, 6);
    check("t2_no_if_yet", n_ifd, 0);
    next();
    wait_done("t2_if", 1'b0, n);
    check("t2_if_latency", n, 18);
    for (int k = 0; k < LB; k++) exp_line[8*k +: 8] = 8'(k) + 8'h5A;
    check("t2_if_line", bus.if_line, exp_line);
    check("t2_ls_count", n_lsd, 1);
    next();
    bus.if_req = 1'b0;
    wait_done("t2_ls2", 1'b1, n);
    check("t2_ls2_latency", n, 6);
    check("t2_overlap", n_ovl, 0);
    bus.ls_req = 1'b0;
    // IO byte store held off by io_buffer_full
    do_reset();
    bus.io_buffer_full = 1'b1;
    ls_go(1'b1, 32'h30000, 2'd0, 32'h41);
    sample();
    check("t3_wr_full0", bus.mem_wr, 0);
    for (int i = 1; i < 5; i++) begin
      next();
      sample();
      check("t3_wr_full", bus.mem_wr, 0);
    end
    next();
    bus.io_buffer_full = 1'b0;
    wait_done("t3", 1'b1, n);
    check("t3_latency", n, 2);
    check("t3_nwrites", wr_a.size(), 1);
    check("t3_addr", wr_a.size() > 0 ? wr_a[0] : 32'hx, 32'h30000);
    check("t3_data", wr_d.size() > 0 ? wr_d[0] : 8'hx, 8'h41);
    check("t3_done_after_wr", lsd_cyc, wr_c.size() > 0 ? wr_c[0] + 1 : -1);
    bus.ls_req = 1'b0;
    // flush aborts a refill at byte 7, pending load granted afterwards
    do_reset();
    bus.if_req = 1'b1;
    bus.if_addr = 32'h2000;
    sample();
    for (int k = 0; k < 7; k++) begin
      next();
      if (k == 1) ls_go(1'b0, 32'h1000, 2'd2, 32'h0);
      sample();
      check("t4_refill_addr", bus.mem_a, 32'h2000 + k);
    end
    next();
    bus.flush = 1'b1;
    sample();
    check("t4_addr7", bus.mem_a, 32'h2007);
    check("t4_if_done_flush", bus.if_done, 0);
    next();
    bus.flush = 1'b0;
    bus.if_req = 1'b0;
    sample();
    check("t4_idle_a", bus.mem_a, 0);
    check("t4_idle_wr", bus.mem_wr, 0);
    next();
    wait_done("t4", 1'b1, n);
    check("t4_ls_latency", n, 5);
    check("t4_ls_rdata", bus.ls_rdata, 32'h44332211);
    check("t4_no_if_done", n_ifd, 0);
    check("t4_nwrites", wr_a.size(), 0);
    bus.ls_req = 1'b0;
    // half store paused by rdy_in for 3 cycles after the first byte
    do_reset();
    ls_go(1'b1, 32'h2000, 2'd1, 32'h0000BEEF);
    sample();
    next();
    sample();
    check("t5_wr0", bus.mem_wr, 1);
    check("t5_a0", bus.mem_a, 32'h2000);
    check("t5_d0", bus.mem_dout, 8'hEF);
    next();
    bus.rdy_in = 1'b0;
    sample();
    check("t5_pause_wr", bus.mem_wr, 0);
    check("t5_pause_a", bus.mem_a, 32'h2000);
    repeat (2) next();
    next();
    bus.rdy_in = 1'b1;
    wait_done("t5", 1'b1, n);
    check("t5_latency", n, 1);
    check("t5_nwrites", wr_a.size(), 2);
    check("t5_d0_log", wr_d.size() > 0 ? wr_d[0] : 8'hx, 8'hEF);
    check("t5_a1", wr_a.size() > 1 ? wr_a[1] : 32'hx, 32'h2001);
    check("t5_d1", wr_d.size() > 1 ? wr_d[1] : 8'hx, 8'hBE);
    bus.ls_req = 1'b0;
    // reset in the middle of a refill
    do_reset();
    bus.if_req = 1'b1;
    bus.if_addr = 32'h2000;
    repeat (5) next();
    rst_in = 1'b1;
    next();
    rst_in = 1'b0;
    bus.if_req = 1'b0;
    sample();
    check_idle_outputs("t6");
    repeat (20) next();
    sample();
    check("t6_no_if_done", n_ifd, 0);
    check("t6_idle_a", bus.mem_a, 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
